// File: rtl/tb_ctrl_periph.sv
// Testbench control/status responder: stdout FIFO, sticky pass/fail/exit flags, 1-cycle OBI response.
// Stalls only STDOUT pushes while full; optional CYCLE counter enabled by TB_CTRL_CYCLE_CNT_EN.
module tb_ctrl_periph #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_data_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [5:0]       reg_idx;
  logic             stdout_wr, push, pop;
  logic [31:0]      rdata_nxt, cycle_rd;
  logic             unused_ok;

  assign unused_ok = ^{addr_i[1:0], be_i[3:1]};

  assign reg_idx = addr_i[7:2];
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);

  // A pop in the same cycle never frees a slot for a stalled push.
  assign stdout_wr = req_i & we_i & (reg_idx == 6'h00) & be_i[0];
  assign gnt_o     = req_i & ~(stdout_wr & full);
  assign push      = gnt_o & stdout_wr;
  assign pop       = stdout_valid_o & stdout_ready_i;

  assign stdout_valid_o = ~empty;
  assign stdout_data_o  = mem[rd_ptr];

`ifdef TB_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle_cnt <= '0;
    else         cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = '0;
`endif

  always_comb begin
    rdata_nxt = '0;
    if (!we_i) begin
      case (reg_idx)
        6'h04: begin
          rdata_nxt[CNT_W-1:0] = count;
          rdata_nxt[16]        = full;
          rdata_nxt[17]        = empty;
          rdata_nxt[18]        = exit_valid_o;
        end
        6'h05:   rdata_nxt = cycle_rd;
        default: rdata_nxt = '0;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= gnt_o;
      if (gnt_o) rdata_o <= rdata_nxt;
    end
  end

  // First EXIT write wins; later ones are acknowledged but change nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else if (gnt_o && we_i) begin
      case (reg_idx)
        6'h01: tests_passed_o <= 1'b1;
        6'h02: tests_failed_o <= 1'b1;
        6'h03: begin
          if (!exit_valid_o) begin
            exit_valid_o <= 1'b1;
            exit_value_o <= wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
